// File: rtl/config_pkg.sv
// Core configuration: the cacheable and scratchpad physical address windows.
package config_pkg;

  typedef struct packed {
    logic [55:0] cached_base;
    logic [55:0] cached_size;
    logic [55:0] spm_base;
    logic [55:0] spm_size;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    cached_base: 56'h0000_0080_000_000,
    cached_size: 56'h0000_0080_000_000,
    spm_base:    56'h0000_0010_000_000,
    spm_size:    56'h0000_0000_010_000
  };

endpackage

// File: rtl/cva6_hpdcache_adapter_pkg.sv
// Shared types for the CVA6 store/AMO to HPDcache adapter: core and cache
// channel structs, AMO FSM states and the AMO opcode translation.
package cva6_hpdcache_adapter_pkg;

  localparam int unsigned INDEX_W = 12;
  localparam int unsigned TAG_W   = 44;
  localparam int unsigned PLEN    = INDEX_W + TAG_W;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = 8;
  localparam int unsigned TID_W   = 8;
  localparam int unsigned SID_W   = 3;

  localparam logic [TID_W-1:0] AMO_TID_DEFAULT = '1;

  typedef logic [SID_W-1:0] hpdcache_req_sid_t;

  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD, HPDCACHE_REQ_STORE, HPDCACHE_REQ_AMO_LR, HPDCACHE_REQ_AMO_SC,
    HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD, HPDCACHE_REQ_AMO_AND,
    HPDCACHE_REQ_AMO_OR, HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX,
    HPDCACHE_REQ_AMO_MAXU, HPDCACHE_REQ_AMO_MIN, HPDCACHE_REQ_AMO_MINU
  } hpdcache_req_op_t;

  typedef enum logic [1:0] {AMO_IDLE, AMO_DRAIN, AMO_REQ, AMO_WAIT} amo_state_e;

  typedef struct packed {
    logic [INDEX_W-1:0] address_index;
    logic [TAG_W-1:0]   address_tag;
    logic [DATA_W-1:0]  data_wdata;
    logic               data_req;
    logic [BE_W-1:0]    data_be;
    logic [1:0]         data_size;
  } dcache_req_i_t;

  typedef struct packed {
    logic               data_gnt;
    logic               data_rvalid;
    logic [TID_W-1:0]   data_rid;
    logic [DATA_W-1:0]  data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic               req;
    amo_t               amo_op;
    logic [1:0]         size;
    logic [63:0]        operand_a;
    logic [63:0]        operand_b;
  } amo_req_t;

  typedef struct packed {
    logic               ack;
    logic [63:0]        result;
  } amo_resp_t;

  typedef struct packed {
    logic uncacheable;
    logic io;
  } hpdcache_pma_t;

  typedef struct packed {
    logic [INDEX_W-1:0] addr_offset;
    logic [DATA_W-1:0]  wdata;
    hpdcache_req_op_t   op;
    logic [BE_W-1:0]    be;
    logic [2:0]         size;
    hpdcache_req_sid_t  sid;
    logic [TID_W-1:0]   tid;
    logic               need_rsp;
    logic               phys_indexed;
    logic [TAG_W-1:0]   addr_tag;
    hpdcache_pma_t      pma;
  } hpdcache_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]  rdata;
    logic [TID_W-1:0]   tid;
  } hpdcache_rsp_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  wdata;
    logic [BE_W-1:0]    be;
    logic [1:0]         size;
  } stbuf_entry_t;

  function automatic hpdcache_req_op_t amo_op_map(input amo_t op);
    case (op)
      AMO_LR:   return HPDCACHE_REQ_AMO_LR;
      AMO_SC:   return HPDCACHE_REQ_AMO_SC;
      AMO_SWAP: return HPDCACHE_REQ_AMO_SWAP;
      AMO_ADD:  return HPDCACHE_REQ_AMO_ADD;
      AMO_AND:  return HPDCACHE_REQ_AMO_AND;
      AMO_OR:   return HPDCACHE_REQ_AMO_OR;
      AMO_XOR:  return HPDCACHE_REQ_AMO_XOR;
      AMO_MAX:  return HPDCACHE_REQ_AMO_MAX;
      AMO_MAXU: return HPDCACHE_REQ_AMO_MAXU;
      AMO_MIN:  return HPDCACHE_REQ_AMO_MIN;
      AMO_MINU: return HPDCACHE_REQ_AMO_MINU;
      default:  return HPDCACHE_REQ_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/cva6_hpdcache_stbuf.sv
// Store skid buffer: circular FIFO with occupancy count. A push is accepted
// when full only if a pop happens in the same cycle.
module cva6_hpdcache_stbuf #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic [7:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  entry_t                       data_i,
  input  logic                         pop_i,
  output entry_t                       data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push, w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign count_o   = r_count;
  assign data_o    = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cva6_hpdcache_st_amo_adapter.sv
// Bridges CVA6 store and AMO ports onto one HPDcache request channel; stores
// are buffered, and an AMO first drains the buffer then owns the channel.
//   state     | meaning
//   AMO_IDLE  | stores accepted; buffered stores issued in order
//   AMO_DRAIN | AMO pending, no new stores, buffer draining
//   AMO_REQ   | AMO request presented until accepted
//   AMO_WAIT  | waiting for the AMO_TID response
module cva6_hpdcache_st_amo_adapter
  import cva6_hpdcache_adapter_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned XLEN = 64,
  parameter int unsigned STBUF_DEPTH = 2,
  parameter logic [TID_W-1:0] AMO_TID = AMO_TID_DEFAULT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  hpdcache_req_sid_t                    hpdcache_req_sid_i,
  input  dcache_req_i_t                        cva6_req_i,
  output dcache_req_o_t                        cva6_req_o,
  input  amo_req_t                             cva6_amo_req_i,
  output amo_resp_t                            cva6_amo_resp_o,
  output logic                                 hpdcache_req_valid_o,
  input  logic                                 hpdcache_req_ready_i,
  output hpdcache_req_t                        hpdcache_req_o,
  input  logic                                 hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t                        hpdcache_rsp_i,
  output logic                                 stbuf_empty_o,
  output logic [$clog2(STBUF_DEPTH+1)-1:0]     stbuf_count_o
);

  localparam int unsigned CNT_W = $clog2(STBUF_DEPTH+1);

  amo_state_e         r_state, w_state_nxt;
  stbuf_entry_t       w_push_entry, w_head;
  logic               w_gnt, w_push, w_pop, w_full, w_empty;
  logic               w_store_valid, w_amo_issue, w_amo_rsp, w_amo_word;
  logic [CNT_W-1:0]   w_count;
  logic [PLEN-1:0]    w_amo_addr, w_paddr;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_rsp_word;
  logic               w_cacheable, w_spm;
  logic               w_unused;

  assign w_unused = ^cva6_amo_req_i.operand_a[63:PLEN];

  assign w_push_entry = '{tag:   cva6_req_i.address_tag,
                          index: cva6_req_i.address_index,
                          wdata: cva6_req_i.data_wdata,
                          be:    cva6_req_i.data_be,
                          size:  cva6_req_i.data_size};

  assign w_gnt         = ~rst_i & ~w_full & (r_state == AMO_IDLE) & ~cva6_amo_req_i.req;
  assign w_push        = w_gnt & cva6_req_i.data_req;
  assign w_store_valid = ~rst_i & ~w_empty & (r_state != AMO_REQ);
  assign w_amo_issue   = ~rst_i & (r_state == AMO_REQ);
  assign w_pop         = w_store_valid & hpdcache_req_ready_i;
  assign w_amo_rsp     = hpdcache_rsp_valid_i & (hpdcache_rsp_i.tid == AMO_TID);

  cva6_hpdcache_stbuf #(
    .DEPTH   (STBUF_DEPTH),
    .entry_t (stbuf_entry_t)
  ) u_stbuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= AMO_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AMO_IDLE:  if (cva6_amo_req_i.req)  w_state_nxt = AMO_DRAIN;
      AMO_DRAIN: if (w_empty)              w_state_nxt = AMO_REQ;
      AMO_REQ:   if (hpdcache_req_ready_i) w_state_nxt = AMO_WAIT;
      AMO_WAIT:  if (w_amo_rsp)            w_state_nxt = AMO_IDLE;
      default:                             w_state_nxt = AMO_IDLE;
    endcase
  end

  // PMA is derived from whichever tag is actually on the channel
  assign w_amo_addr  = cva6_amo_req_i.operand_a[PLEN-1:0];
  assign w_amo_word  = (cva6_amo_req_i.size == 2'b10);
  assign w_tag       = (r_state == AMO_REQ) ? w_amo_addr[PLEN-1:INDEX_W] : w_head.tag;
  assign w_paddr     = {w_tag, {INDEX_W{1'b0}}};
  assign w_cacheable = (w_paddr - CVA6Cfg.cached_base) < CVA6Cfg.cached_size;
  assign w_spm       = (w_paddr - CVA6Cfg.spm_base) < CVA6Cfg.spm_size;

  always_comb begin
    hpdcache_req_o                 = '0;
    hpdcache_req_o.sid             = hpdcache_req_sid_i;
    hpdcache_req_o.phys_indexed    = 1'b1;
    hpdcache_req_o.addr_tag        = w_tag;
    hpdcache_req_o.pma.uncacheable = ~w_cacheable & ~w_spm;
    hpdcache_req_o.pma.io          = 1'b0;
    if (r_state == AMO_REQ) begin
      hpdcache_req_o.addr_offset = w_amo_addr[INDEX_W-1:0];
      hpdcache_req_o.op          = amo_op_map(cva6_amo_req_i.amo_op);
      hpdcache_req_o.size        = {1'b0, cva6_amo_req_i.size};
      hpdcache_req_o.tid         = AMO_TID;
      hpdcache_req_o.need_rsp    = 1'b1;
      if (XLEN == 64) begin
        hpdcache_req_o.wdata = w_amo_word ? {2{cva6_amo_req_i.operand_b[31:0]}}
                                          : cva6_amo_req_i.operand_b;
        hpdcache_req_o.be    = !w_amo_word ? 8'hff :
                               cva6_amo_req_i.operand_a[2] ? 8'hf0 : 8'h0f;
      end else begin
        hpdcache_req_o.wdata = {32'b0, cva6_amo_req_i.operand_b[31:0]};
        hpdcache_req_o.be    = 8'h0f;
      end
    end else begin
      hpdcache_req_o.addr_offset = w_head.index;
      hpdcache_req_o.wdata       = w_head.wdata;
      hpdcache_req_o.op          = HPDCACHE_REQ_STORE;
      hpdcache_req_o.be          = w_head.be;
      hpdcache_req_o.size        = {1'b0, w_head.size};
    end
  end

  assign w_rsp_word = cva6_amo_req_i.operand_a[2] ? hpdcache_rsp_i.rdata[63:32]
                                                  : hpdcache_rsp_i.rdata[31:0];

  always_comb begin
    cva6_amo_resp_o     = '0;
    cva6_amo_resp_o.ack = ~rst_i & (r_state == AMO_WAIT) & w_amo_rsp;
    if (XLEN == 64)
      cva6_amo_resp_o.result = w_amo_word ? {{32{w_rsp_word[31]}}, w_rsp_word}
                                          : hpdcache_rsp_i.rdata;
    else
      cva6_amo_resp_o.result = {32'b0, hpdcache_rsp_i.rdata[31:0]};

    cva6_req_o             = '0;
    cva6_req_o.data_gnt    = w_gnt;
    cva6_req_o.data_rvalid = ~rst_i & hpdcache_rsp_valid_i & ~w_amo_rsp;
    cva6_req_o.data_rid    = hpdcache_rsp_i.tid;
    cva6_req_o.data_rdata  = hpdcache_rsp_i.rdata;
  end

  assign hpdcache_req_valid_o = w_store_valid | w_amo_issue;
  assign stbuf_empty_o        = rst_i | (w_empty & (r_state == AMO_IDLE));
  assign stbuf_count_o        = rst_i ? '0 : w_count;

endmodule

// File: tb/tb_cva6_hpdcache_st_amo_adapter.sv
// Directed bench for the store/AMO adapter and its store buffer.
module tb_cva6_hpdcache_st_amo_adapter;
  import cva6_hpdcache_adapter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  hpdcache_req_sid_t sid;
  dcache_req_i_t     creq;
  dcache_req_o_t     cresp;
  amo_req_t          amo;
  amo_resp_t         amo_rsp;
  logic              hv, hr, rv;
  hpdcache_req_t     hreq;
  hpdcache_rsp_t     rsp;
  logic              empty;
  logic [1:0]        cnt;

  logic              f_push, f_pop, f_full, f_empty;
  logic [15:0]       f_din, f_dout;
  logic [1:0]        f_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cva6_hpdcache_st_amo_adapter dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .hpdcache_req_sid_i   (sid),
    .cva6_req_i           (creq),
    .cva6_req_o           (cresp),
    .cva6_amo_req_i       (amo),
    .cva6_amo_resp_o      (amo_rsp),
    .hpdcache_req_valid_o (hv),
    .hpdcache_req_ready_i (hr),
    .hpdcache_req_o       (hreq),
    .hpdcache_rsp_valid_i (rv),
    .hpdcache_rsp_i       (rsp),
    .stbuf_empty_o        (empty),
    .stbuf_count_o        (cnt)
  );

  cva6_hpdcache_stbuf #(.DEPTH(2), .entry_t(logic [15:0])) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (f_push),
    .data_i  (f_din),
    .pop_i   (f_pop),
    .data_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [43:0] tag, input logic [11:0] idx, input logic [63:0] wd);
    creq.address_tag   = tag;
    creq.address_index = idx;
    creq.data_wdata    = wd;
    creq.data_be       = 8'hff;
    creq.data_size     = 2'b11;
    creq.data_req      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sid = 3'd2; creq = '0; amo = '0; hr = 1'b0; rv = 1'b0; rsp = '0;
    f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    creq.data_req = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(hv), 64'd0);
    chk("rst_gnt",   64'(cresp.data_gnt), 64'd0);
    chk("rst_ack",   64'(amo_rsp.ack), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(cnt), 64'd0);
    creq.data_req = 1'b0;
    rst = 1'b0;

    // store buffer alone: push+pop while full keeps count and order
    f_push = 1'b1; f_din = 16'h1111; tick();
    f_din = 16'h2222; tick();
    f_din = 16'h3333; f_pop = 1'b1; #1;
    chk("fifo_full",  64'(f_full), 64'd1);
    chk("fifo_head0", 64'(f_dout), 64'h1111);
    tick();
    chk("fifo_pp_count", 64'(f_cnt), 64'd2);
    chk("fifo_pp_head",  64'(f_dout), 64'h2222);
    f_push = 1'b0; tick();
    chk("fifo_head2", 64'(f_dout), 64'h3333);
    chk("fifo_cnt1",  64'(f_cnt), 64'd1);
    tick();
    chk("fifo_empty", 64'(f_empty), 64'd1);
    f_pop = 1'b0;

    // store burst with ready low: A, B accepted, C stalled
    set_store(44'h80001, 12'h010, 64'hAAAA_AAAA_AAAA_AAAA); #1;
    chk("gnt_a", 64'(cresp.data_gnt), 64'd1);
    chk("no_bypass", 64'(hv), 64'd0);
    tick();
    set_store(44'h00001, 12'h020, 64'hBBBB_BBBB_BBBB_BBBB); #1;
    chk("cnt_1",       64'(cnt), 64'd1);
    chk("valid_a",     64'(hv), 64'd1);
    chk("wdata_a",     hreq.wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("op_store",    64'(hreq.op), 64'(HPDCACHE_REQ_STORE));
    chk("tid_store",   64'(hreq.tid), 64'd0);
    chk("needrsp_st",  64'(hreq.need_rsp), 64'd0);
    chk("phys_idx",    64'(hreq.phys_indexed), 64'd1);
    chk("sid",         64'(hreq.sid), 64'd2);
    chk("offset_a",    64'(hreq.addr_offset), 64'h010);
    chk("size_a",      64'(hreq.size), 64'd3);
    chk("uc_a",        64'(hreq.pma.uncacheable), 64'd0);
    tick();
    set_store(44'h10000, 12'h030, 64'hCCCC_CCCC_CCCC_CCCC); #1;
    chk("cnt_2",     64'(cnt), 64'd2);
    chk("gnt_full",  64'(cresp.data_gnt), 64'd0);
    tick();
    chk("cnt_2_hold",   64'(cnt), 64'd2);
    chk("stall_stable", hreq.wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    hr = 1'b1; tick();
    chk("issue_b",  hreq.wdata, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("uc_b",     64'(hreq.pma.uncacheable), 64'd1);
    chk("gnt_c",    64'(cresp.data_gnt), 64'd1);
    tick();
    chk("pp_count", 64'(cnt), 64'd1);
    chk("issue_c",  hreq.wdata, 64'hCCCC_CCCC_CCCC_CCCC);
    chk("uc_c_spm", 64'(hreq.pma.uncacheable), 64'd0);
    creq.data_req = 1'b0; tick();
    chk("drained_cnt",   64'(cnt), 64'd0);
    chk("drained_valid", 64'(hv), 64'd0);

    // word AMO_ADD on the upper word
    hr = 1'b0;
    amo.req = 1'b1; amo.amo_op = AMO_ADD; amo.size = 2'b10;
    amo.operand_a = 64'h8000_0004; amo.operand_b = 64'h8000_0001;
    creq.data_req = 1'b1; #1;
    chk("gnt_amo_req", 64'(cresp.data_gnt), 64'd0);
    tick();
    chk("drain_valid", 64'(hv), 64'd0);
    chk("drain_empty_o", 64'(empty), 64'd0);
    tick();
    chk("amo_valid",  64'(hv), 64'd1);
    chk("amo_op",     64'(hreq.op), 64'(HPDCACHE_REQ_AMO_ADD));
    chk("amo_be",     64'(hreq.be), 64'hf0);
    chk("amo_wdata",  hreq.wdata, 64'h8000_0001_8000_0001);
    chk("amo_tid",    64'(hreq.tid), 64'hff);
    chk("amo_needrsp",64'(hreq.need_rsp), 64'd1);
    chk("amo_offset", 64'(hreq.addr_offset), 64'h004);
    chk("amo_tag",    64'(hreq.addr_tag), 64'h80000);
    tick();
    chk("amo_stable", hreq.wdata, 64'h8000_0001_8000_0001);
    hr = 1'b1; tick();
    hr = 1'b0; #1;
    chk("wait_valid", 64'(hv), 64'd0);
    rv = 1'b1; rsp.tid = 8'd5; rsp.rdata = 64'h1234; #1;
    chk("fwd_rvalid", 64'(cresp.data_rvalid), 64'd1);
    chk("fwd_rid",    64'(cresp.data_rid), 64'd5);
    chk("fwd_rdata",  cresp.data_rdata, 64'h1234);
    chk("fwd_no_ack", 64'(amo_rsp.ack), 64'd0);
    tick();
    rsp.tid = 8'hff; rsp.rdata = 64'hFFFF_FFFE_0000_0000; #1;
    chk("amo_ack",    64'(amo_rsp.ack), 64'd1);
    chk("amo_result", amo_rsp.result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("amo_no_fwd", 64'(cresp.data_rvalid), 64'd0);
    tick();
    rv = 1'b0; amo.req = 1'b0; creq.data_req = 1'b0; #1;
    chk("ack_pulse",  64'(amo_rsp.ack), 64'd0);
    chk("idle_empty", 64'(empty), 64'd1);
    chk("idle_gnt",   64'(cresp.data_gnt), 64'd1);

    // unknown opcode falls back to LOAD, lower word sign-extended
    amo.req = 1'b1; amo.amo_op = AMO_CAS1; amo.size = 2'b10;
    amo.operand_a = 64'h8000_0000; amo.operand_b = 64'h0;
    tick(); tick();
    chk("unk_op_load", 64'(hreq.op), 64'(HPDCACHE_REQ_LOAD));
    chk("unk_be",      64'(hreq.be), 64'h0f);
    hr = 1'b1; tick();
    hr = 1'b0; rv = 1'b1; rsp.tid = 8'hff; rsp.rdata = 64'h0000_0000_8000_0000; #1;
    chk("lo_ack",    64'(amo_rsp.ack), 64'd1);
    chk("lo_result", amo_rsp.result, 64'hFFFF_FFFF_8000_0000);
    tick();
    rv = 1'b0; amo.req = 1'b0;

    // AMO behind two buffered stores
    set_store(44'h80002, 12'h040, 64'hDDDD_DDDD_DDDD_DDDD); tick();
    set_store(44'h80003, 12'h050, 64'hEEEE_EEEE_EEEE_EEEE); tick();
    set_store(44'h80004, 12'h060, 64'hFFFF_0000_FFFF_0000);
    amo.req = 1'b1; amo.amo_op = AMO_SWAP; amo.size = 2'b11;
    amo.operand_a = 64'h8000_0008; amo.operand_b = 64'h0123_4567_89AB_CDEF; #1;
    chk("pre_drain_cnt", 64'(cnt), 64'd2);
    tick();
    chk("drain_d",      hreq.wdata, 64'hDDDD_DDDD_DDDD_DDDD);
    chk("drain_gnt0",   64'(cresp.data_gnt), 64'd0);
    hr = 1'b1; tick();
    chk("drain_e",      hreq.wdata, 64'hEEEE_EEEE_EEEE_EEEE);
    chk("drain_gnt1",   64'(cresp.data_gnt), 64'd0);
    tick();
    chk("drain_cnt0",   64'(cnt), 64'd0);
    chk("drain_gap",    64'(hv), 64'd0);
    tick();
    chk("swap_valid",   64'(hv), 64'd1);
    chk("swap_op",      64'(hreq.op), 64'(HPDCACHE_REQ_AMO_SWAP));
    chk("swap_be",      64'(hreq.be), 64'hff);
    chk("swap_wdata",   hreq.wdata, 64'h0123_4567_89AB_CDEF);
    chk("swap_gnt",     64'(cresp.data_gnt), 64'd0);
    tick();
    hr = 1'b0; #1;
    chk("swap_wait_valid", 64'(hv), 64'd0);
    chk("swap_wait_gnt",   64'(cresp.data_gnt), 64'd0);

    // reset while waiting: late response must not ack
    rst = 1'b1; #1;
    chk("rst_mid_gnt", 64'(cresp.data_gnt), 64'd0);
    tick();
    rst = 1'b0; amo.req = 1'b0; creq.data_req = 1'b0; #1;
    chk("post_rst_cnt",   64'(cnt), 64'd0);
    chk("post_rst_empty", 64'(empty), 64'd1);
    rv = 1'b1; rsp.tid = 8'hff; #1;
    chk("late_rsp_ack",   64'(amo_rsp.ack), 64'd0);
    chk("late_rsp_fwd",   64'(cresp.data_rvalid), 64'd0);
    tick();
    rv = 1'b0;

    // reset mid-drain discards the buffered store
    set_store(44'h80005, 12'h070, 64'h5555_5555_5555_5555); tick();
    creq.data_req = 1'b0; amo.req = 1'b1; amo.amo_op = AMO_ADD; amo.size = 2'b11;
    tick();
    chk("mid_drain_cnt", 64'(cnt), 64'd1);
    rst = 1'b1; tick();
    rst = 1'b0; amo.req = 1'b0; #1;
    chk("drain_rst_cnt",   64'(cnt), 64'd0);
    chk("drain_rst_valid", 64'(hv), 64'd0);
    chk("drain_rst_gnt",   64'(cresp.data_gnt), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
